sha256_block_engine: RTL and testbench

- Iterative, multi-block SHA-256 compression engine and the parametrised successor of the single-block hash core.
- Accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains the hash state across blocks of one message.
- Runs the 64 rounds over 64/ROUNDS_PER_CYCLE cycles, with a 16-word rolling message schedule.
- Sits between the padding/framing front end and the digest consumer. It reuses the existing S0/S1/Ch/Maj round functions and the K-constant table.

---
 rtl/sha256_block_engine.sv | 217 +++++++++++++++++++++
 tb/tb_sha256_block_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_engine.sv
// sha256_block_engine: iterative multi-block SHA-256 compression engine.
// Takes pre-padded 512-bit blocks over valid/ready, chains H across the
// blocks of one message and runs 64 rounds in 64/ROUNDS_PER_CYCLE cycles
// using a rolling 16-word message schedule window.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   blk_valid/blk_ready   block handshake; blk_data word W0 in [511:480]
//   blk_first, blk_last   load IV before compressing / emit digest after
//   digest_valid/ready    digest handshake, digest held until accepted
//   digest                {H0..H7}, H0 in the MSBs
//   busy                  high in every state except IDLE
// Optional: define SHA256_BLOCK_ENGINE_SHA224_EN to add input mode_224
// (sampled on a blk_first accept) selecting the SHA-224 IV and a
// {H0..H6, 32'h0} digest.
module sha256_block_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
  ,
  input  logic         mode_224
`endif
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] T_LAST = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE, S_HOLD} state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  state_t        r_state;
  logic [5:0]    r_t;
  logic [31:0]   r_w [16];
  logic [31:0]   r_h [8];
  logic [31:0]   r_v [8];       // working variables a..h at index 0..7
  logic          r_last;
  logic          r_blk_ready;
  logic          r_digest_valid;
  logic [255:0]  r_digest;
  logic          r_busy;
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
  logic          r_mode224;
`endif

  logic [31:0]   w_win_next [16];
  logic [31:0]   w_nv [8];
  logic [31:0]   w_hnew [8];
  logic [31:0]   w_iv [8];
  logic [255:0]  w_digest;

  // R chained rounds plus the schedule words they consume.
  always_comb begin : b_round
    logic [31:0] ext [16+R];
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = '0;
    t2 = '0;
    for (int unsigned i = 0; i < 16; i++) ext[i] = r_w[i];
    // Words beyond the window; ext[j] always holds W[t+j].
    for (int unsigned j = 0; j < R; j++)
      ext[16+j] = ssig1(ext[j+14]) + ext[j+9] + ssig0(ext[j+1]) + ext[j];
    for (int unsigned i = 0; i < 16; i++) w_win_next[i] = ext[i+R];
    for (int unsigned i = 0; i < 8; i++) w_nv[i] = r_v[i];
    for (int unsigned j = 0; j < R; j++) begin
      t1 = w_nv[7] + bsig1(w_nv[4]) + ((w_nv[4] & w_nv[5]) ^ (~w_nv[4] & w_nv[6]))
         + K[r_t + 6'(j)] + ext[j];
      t2 = bsig0(w_nv[0]) + ((w_nv[0] & w_nv[1]) ^ (w_nv[0] & w_nv[2]) ^ (w_nv[1] & w_nv[2]));
      w_nv[7] = w_nv[6];
      w_nv[6] = w_nv[5];
      w_nv[5] = w_nv[4];
      w_nv[4] = w_nv[3] + t1;
      w_nv[3] = w_nv[2];
      w_nv[2] = w_nv[1];
      w_nv[1] = w_nv[0];
      w_nv[0] = t1 + t2;
    end
  end

  // Chaining sum, digest packing and IV selection.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) w_hnew[i] = r_h[i] + r_v[i];
    w_digest = {w_hnew[0], w_hnew[1], w_hnew[2], w_hnew[3],
                w_hnew[4], w_hnew[5], w_hnew[6], w_hnew[7]};
    w_iv = IV256;
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    if (r_mode224) w_digest[31:0] = 32'h0;
    if (mode_224) begin
      w_iv = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    end
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_t            <= '0;
      r_last         <= 1'b0;
      r_blk_ready    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_digest       <= '0;
      r_busy         <= 1'b0;
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
      r_mode224      <= 1'b0;
`endif
      for (int unsigned i = 0; i < 16; i++) r_w[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_h[i] <= '0;
        r_v[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_blk_ready <= 1'b1;
          if (blk_valid && r_blk_ready) begin
            for (int unsigned i = 0; i < 16; i++) r_w[i] <= blk_data[32*(15-i) +: 32];
            for (int unsigned i = 0; i < 8; i++) begin
              r_h[i] <= blk_first ? w_iv[i] : r_h[i];
              r_v[i] <= blk_first ? w_iv[i] : r_h[i];
            end
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
            if (blk_first) r_mode224 <= mode_224;
`endif
            r_last      <= blk_last;
            r_t         <= '0;
            r_state     <= S_ROUND;
            r_busy      <= 1'b1;
            r_blk_ready <= 1'b0;
          end
        end
        S_ROUND: begin
          r_w <= w_win_next;
          r_v <= w_nv;
          r_t <= r_t + 6'(R);
          if (r_t == T_LAST) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_h <= w_hnew;
          if (r_last) begin
            r_digest       <= w_digest;
            r_digest_valid <= 1'b1;
            r_state        <= S_HOLD;
          end else begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_blk_ready <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_digest_valid && digest_ready) begin
            r_digest_valid <= 1'b0;
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_blk_ready    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign blk_ready    = r_blk_ready;
  assign digest_valid = r_digest_valid;
  assign digest       = r_digest;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Bench for sha256_block_engine: known-answer vectors, latency,
// backpressure, mid-block reset and the R=2/R=4 unrolled variants.
module tb_sha256_block_engine;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};
  localparam logic [255:0] DG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DG_2BLK =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         digest_valid;
  logic         digest_ready = 1'b1;
  logic [255:0] digest;
  logic         busy;
  logic         mode_224 = 1'b0;

  logic v2 = 1'b0, v4 = 1'b0;
  logic rdy2, rdy4, dv2, dv4, bz2, bz4;
  logic [255:0] dg2, dg4;

  sha256_block_engine #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest(digest), .busy(busy)
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    , .mode_224(mode_224)
`endif
  );

  sha256_block_engine #(.ROUNDS_PER_CYCLE(2)) u_dut_r2 (
    .clk(clk), .rst_n(rst_n), .blk_valid(v2), .blk_ready(rdy2),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .digest_valid(dv2), .digest_ready(1'b1), .digest(dg2), .busy(bz2)
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    , .mode_224(mode_224)
`endif
  );

  sha256_block_engine #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
    .clk(clk), .rst_n(rst_n), .blk_valid(v4), .blk_ready(rdy4),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .digest_valid(dv4), .digest_ready(1'b1), .digest(dg4), .busy(bz4)
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    , .mode_224(mode_224)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected digest and accept cycle queued at each last-block accept.
  logic [255:0] exp_digest = '0;
  logic [255:0] sb_q [$];
  int           acc_q [$];
  logic         dv_prev = 1'b0;
  int           mon_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      dv_prev = 1'b0;
    end else begin
      if (blk_valid && blk_ready && blk_last) begin
        sb_q.push_back(exp_digest);
        acc_q.push_back(cyc + 1);
      end
      if (digest_valid && !dv_prev) begin
        if (acc_q.size() == 0) check("spurious_digest_valid", 256'(1), 256'(0));
        else begin
          mon_acc = acc_q.pop_front();
          check("digest_latency", 256'(cyc - mon_acc), 256'(65));
        end
      end
      if (digest_valid && digest_ready) begin
        if (sb_q.size() == 0) check("unexpected_digest", digest, '0);
        else check("digest_value", digest, sb_q.pop_front());
      end
      dv_prev = digest_valid;
    end
  end

  task automatic do_reset();
    blk_valid = 1'b0; v2 = 1'b0; v4 = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    acc_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [511:0] d, input logic f, input logic l, input logic [255:0] e);
    int k;
    @(posedge clk); #1;
    blk_data = d; blk_first = f; blk_last = l; exp_digest = e; blk_valid = 1'b1;
    k = 0;
    while (!blk_ready && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) check("accept_timeout", 256'(1), 256'(0));
    else begin
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 1000) check("idle_timeout", 256'(1), 256'(0));
  endtask

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [255:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [255:0] snap;
    int bad, k, lat2, lat4;
    logic [255:0] cap2, cap4;

    tbl[0] = '{BLK_ABC,   1'b1, 1'b1, DG_ABC};
    tbl[1] = '{BLK_EMPTY, 1'b1, 1'b1, DG_EMPTY};
    tbl[2] = '{BLK_2A,    1'b1, 1'b0, '0};
    tbl[3] = '{BLK_2B,    1'b0, 1'b1, DG_2BLK};
    tbl[4] = '{BLK_2A,    1'b1, 1'b0, '0};      // abandoned by the next first block
    tbl[5] = '{BLK_ABC,   1'b1, 1'b1, DG_ABC};

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_blk_ready", 256'(blk_ready), 256'(0));
    check("rst_digest_valid", 256'(digest_valid), 256'(0));
    check("rst_digest", digest, '0);
    check("rst_busy", 256'(busy), 256'(0));
    do_reset();
    @(posedge clk); #1;
    check("idle_blk_ready", 256'(blk_ready), 256'(1));

    // Known-answer vectors through the scoreboard.
    for (int i = 0; i < 6; i++) send(tbl[i].data, tbl[i].first, tbl[i].last, tbl[i].exp);
    wait_idle();
    check("digest_kept_after_accept", digest, DG_ABC);

    // Digest backpressure with a pending block.
    digest_ready = 1'b0;
    send(BLK_ABC, 1'b1, 1'b1, DG_ABC);
    k = 0;
    while (!digest_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_digest_valid_seen", 256'(digest_valid), 256'(1));
    snap = digest;
    blk_data = BLK_EMPTY; blk_first = 1'b1; blk_last = 1'b1; exp_digest = DG_EMPTY;
    blk_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!digest_valid || digest !== snap || blk_ready) bad++;
    end
    check("bp_hold_violations", 256'(bad), 256'(0));
    check("bp_held_digest", digest, DG_ABC);
    digest_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_handshake", 256'(blk_ready), 256'(1));
    check("bp_valid_cleared", 256'(digest_valid), 256'(0));
    @(posedge clk); #1;
    check("bp_pending_accepted", 256'(busy), 256'(1));
    blk_valid = 1'b0;
    wait_idle();

    // Reset in round 30 of the first block of a two-block message.
    send(BLK_2A, 1'b1, 1'b0, '0);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_blk_ready", 256'(blk_ready), 256'(0));
    check("midrst_digest_valid", 256'(digest_valid), 256'(0));
    check("midrst_digest", digest, '0);
    check("midrst_busy", 256'(busy), 256'(0));
    do_reset();
    send(BLK_ABC, 1'b1, 1'b1, DG_ABC);
    wait_idle();

    // Unrolled variants: empty message at R=2 and R=4.
    @(posedge clk); #1;
    blk_data = BLK_EMPTY; blk_first = 1'b1; blk_last = 1'b1;
    check("r2_r4_ready", 256'({rdy2, rdy4}), 256'(2'b11));
    v2 = 1'b1; v4 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; v4 = 1'b0;
    check("r2_r4_busy", 256'({bz2, bz4}), 256'(2'b11));
    lat2 = -1; lat4 = -1; cap2 = '0; cap4 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dv2 && lat2 < 0) begin lat2 = c; cap2 = dg2; end
      if (dv4 && lat4 < 0) begin lat4 = c; cap4 = dg4; end
    end
    check("r2_latency", 256'(lat2), 256'(33));
    check("r4_latency", 256'(lat4), 256'(17));
    check("r2_digest", cap2, DG_EMPTY);
    check("r4_digest", cap4, DG_EMPTY);

`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    mode_224 = 1'b1;
    send(BLK_ABC, 1'b1, 1'b1,
         256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
    wait_idle();
    mode_224 = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
